// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall sequencer for the 5-stage pipeline: drives stage-register
// enables/bubbles, ALU operand forwarding selects, memory-wait freeze and a stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             pcsrc_taken,
    input  logic [4:0]       ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mreq,
    input  logic             mem_ready,
    output logic             wpcir,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    logic [1:0] state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;
    logic       freeze;
    logic       ldstall;

    // EX result wins over MEM; a load still in EX cannot forward and falls through to MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        if (e_wreg && (e_rn != 5'd0) && (e_rn == r) && !e_m2reg)
            return 2'b01;
        else if (m_wreg && (m_rn != 5'd0) && (m_rn == r))
            return m_m2reg ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwda = fwd_sel(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        fwdb = fwd_sel(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
    end

    always_comb begin
        ldstall = ewreg && em2reg && (ern != 5'd0) &&
                  ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
        freeze  = ((state == RUN) && mreq && !mem_ready) ||
                  (state == WAIT) || (state == HALT);

        wpcir        = !(freeze || ldstall);
        idex_en      = !freeze;
        exmem_en     = !freeze;
        memwb_bubble = freeze;
        idex_bubble  = ldstall && !freeze;
        ifid_flush   = pcsrc_taken && !freeze && !ldstall;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = mem_err;
        case (state)
            RUN: begin
                if (mreq && !mem_ready) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TIMEOUT) begin
                    state_nxt = HALT;
                    err_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            HALT: begin
                err_nxt = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt <= '0;
        else if ((freeze || ldstall) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal cases plus randomized
// traffic compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TO  = 3;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic clrn;
    logic [4:0] rs, rt, ern, mrn;
    logic use_rs, use_rt, pcsrc_taken, ewreg, em2reg, mwreg, mm2reg, mreq, mem_ready;
    logic wpcir, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_bubble, mem_err;
    logic [1:0] fwda, fwdb;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .pcsrc_taken(pcsrc_taken), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .mreq(mreq), .mem_ready(mem_ready),
        .wpcir(wpcir), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .fwda(fwda), .fwdb(fwdb), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Model: memory access outstanding for m_waited cycles, halted after timeout.
    bit m_waiting, m_halted, m_err;
    int m_waited, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int fwd_model(input logic [4:0] r);
        if (ewreg && ern != 0 && ern == r && !em2reg) return 1;
        if (mwreg && mrn != 0 && mrn == r) return mm2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic bit frz_model();
        return m_halted || m_waiting || (mreq && !mem_ready);
    endfunction

    function automatic bit ld_model();
        return ewreg && em2reg && ern != 0 &&
               ((use_rs && ern == rs) || (use_rt && ern == rt));
    endfunction

    task automatic check_outputs();
        bit f, l;
        f = frz_model();
        l = ld_model();
        chk("wpcir", 32'(wpcir), 32'(!(f || l)));
        chk("ifid_flush", 32'(ifid_flush), 32'(pcsrc_taken && !f && !l));
        chk("idex_bubble", 32'(idex_bubble), 32'(l && !f));
        chk("idex_en", 32'(idex_en), 32'(!f));
        chk("exmem_en", 32'(exmem_en), 32'(!f));
        chk("memwb_bubble", 32'(memwb_bubble), 32'(f));
        chk("fwda", 32'(fwda), 32'(fwd_model(rs)));
        chk("fwdb", 32'(fwdb), 32'(fwd_model(rt)));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    endtask

    task automatic model_clock();
        if (frz_model() || ld_model())
            m_stalls = (m_stalls >= SAT) ? SAT : m_stalls + 1;
        if (m_halted) begin
            m_err = 1;
        end else if (m_waiting) begin
            if (mem_ready) begin
                m_waiting = 0;
                m_waited  = 0;
            end else if (m_waited >= TO) begin
                m_waiting = 0;
                m_halted  = 1;
                m_err     = 1;
            end else begin
                m_waited++;
            end
        end else if (mreq && !mem_ready) begin
            m_waiting = 1;
            m_waited  = 1;
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_halted = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    endtask

    task automatic clear_inputs();
        rs = 0; rt = 0; ern = 0; mrn = 0; use_rs = 0; use_rt = 0; pcsrc_taken = 0;
        ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0; mreq = 0; mem_ready = 0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // Async reset asserted mid-cycle; outputs must revert before any clock edge.
    task automatic do_reset();
        clrn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        clear_inputs();
        clrn = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset
        do_reset();
        settle();
        chk("lit_reset_stall", 32'(stall_cnt), 32'd0);
        chk("lit_reset_err", 32'(mem_err), 32'd0);
        chk("lit_reset_wpcir", 32'(wpcir), 32'd1);

        // ALU chain
        ewreg = 1; ern = 3; rs = 3; use_rs = 1; rt = 4; use_rt = 1;
        settle();
        chk("lit_alu_fwda", 32'(fwda), 32'd1);
        chk("lit_alu_fwdb", 32'(fwdb), 32'd0);
        chk("lit_alu_wpcir", 32'(wpcir), 32'd1);
        chk("lit_alu_stall", 32'(stall_cnt), 32'd0);
        advance();

        // Load-use then MEM load forwarding
        clear_inputs();
        ewreg = 1; em2reg = 1; ern = 5; use_rt = 1; rt = 5;
        settle();
        chk("lit_ld_wpcir", 32'(wpcir), 32'd0);
        chk("lit_ld_bubble", 32'(idex_bubble), 32'd1);
        advance();
        clear_inputs();
        mwreg = 1; mm2reg = 1; mrn = 5; use_rt = 1; rt = 5;
        settle();
        chk("lit_ld_fwdb", 32'(fwdb), 32'd3);
        chk("lit_ld_wpcir2", 32'(wpcir), 32'd1);
        chk("lit_ld_stall", 32'(stall_cnt), 32'd1);
        advance();

        // Register 0 and EX-over-MEM priority
        clear_inputs();
        ewreg = 1; mwreg = 1; ern = 0; mrn = 0; rs = 0;
        settle();
        chk("lit_r0_fwda", 32'(fwda), 32'd0);
        ern = 7; mrn = 7; rs = 7;
        settle();
        chk("lit_prio_fwda", 32'(fwda), 32'd1);
        advance();

        // Memory wait: 3 not-ready cycles then ready
        clear_inputs();
        do_reset();
        mreq = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            chk("lit_wait_bubble", 32'(memwb_bubble), 32'd1);
            chk("lit_wait_exmem", 32'(exmem_en), 32'd0);
            advance();
        end
        clear_inputs();
        settle();
        chk("lit_wait_run", 32'(exmem_en), 32'd1);
        chk("lit_wait_stall", 32'(stall_cnt), 32'd4);
        advance();

        // Timeout into HALT, then reset mid-HALT
        do_reset();
        mreq = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("lit_to_err_pre", 32'(mem_err), 32'd0);
            advance();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lit_halt_err", 32'(mem_err), 32'd1);
            chk("lit_halt_wpcir", 32'(wpcir), 32'd0);
            advance();
        end
        clrn = 1'b0;
        #1;
        model_reset();
        chk("lit_rst_err", 32'(mem_err), 32'd0);
        chk("lit_rst_wpcir", 32'(wpcir), 32'd1);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;

        // Simultaneous freeze, load-use and branch
        clear_inputs();
        mreq = 1; ewreg = 1; em2reg = 1; ern = 5; use_rs = 1; rs = 5; pcsrc_taken = 1;
        settle();
        chk("lit_sim_bubble", 32'(idex_bubble), 32'd0);
        chk("lit_sim_flush", 32'(ifid_flush), 32'd0);
        chk("lit_sim_wpcir", 32'(wpcir), 32'd0);
        advance();
        mem_ready = 1;
        settle();
        advance();
        clear_inputs();
        pcsrc_taken = 1;
        settle();
        chk("lit_br_flush", 32'(ifid_flush), 32'd1);
        advance();
        pcsrc_taken = 0;
        settle();
        chk("lit_br_flush_off", 32'(ifid_flush), 32'd0);
        advance();

        // Saturation of the stall counter
        do_reset();
        ewreg = 1; em2reg = 1; ern = 9; use_rs = 1; rs = 9;
        for (int i = 0; i < SAT + 8; i++) begin
            settle();
            advance();
        end
        settle();
        chk("lit_sat", 32'(stall_cnt), 32'(SAT));
        advance();

        // Randomized traffic
        clear_inputs();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3));
            mrn = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom); use_rt = 1'($urandom);
            ewreg = 1'($urandom); em2reg = 1'($urandom);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            pcsrc_taken = ($urandom_range(0, 3) == 0);
            mreq = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                settle();
                advance();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
